// File: rtl/lcd_frame_scheduler.sv
// Frame-granular round-robin scheduler in front of the LCD pixel FIFO write port.
// Optional stall abort with colour padding is enabled by defining LCD_SCHED_TIMEOUT_EN.
module lcd_frame_scheduler #(
  parameter int          NUM_SRC   = 3,
  parameter int          H_ACTIVE  = 480,
  parameter int          V_ACTIVE  = 272,
  parameter int          TIMEOUT   = 1024,
  parameter logic [23:0] PAD_COLOR = 24'h000000
) (
  input  logic                    clk_12,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      req,
  output logic [NUM_SRC-1:0]      new_frame,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [24*NUM_SRC-1:0]   src_color,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [23:0]             fifo_data,
  output logic                    fifo_wrreq,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  output logic [NUM_SRC-1:0]      grant,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    aborted
);

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
  localparam int SEL_W     = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_TOTAL - 1);
  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
`ifdef LCD_SCHED_TIMEOUT_EN
  localparam logic [2:0] PAD    = 3'd4;
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
`endif

  logic [2:0]         state_r;
  logic [NUM_SRC-1:0] grant_r;
  logic [NUM_SRC-1:0] new_frame_r;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   ptr_r;
  logic [CNT_W-1:0]   pix_cnt_r;
  logic               busy_r;
  logic               frame_done_r;
  logic               aborted_r;
`ifdef LCD_SCHED_TIMEOUT_EN
  logic [STALL_W-1:0] stall_cnt_r;
`else
  logic               unused_cfg_s;
  assign unused_cfg_s = (^PAD_COLOR) ^ (TIMEOUT > 0);
`endif

  logic               pick_valid_s;
  logic [SEL_W-1:0]   pick_idx_s;
  logic               sel_valid_s;
  logic [23:0]        sel_color_s;
  logic               xfer_s;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {SEL_W{1'b0}};
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pick_valid_s = pick_valid_s | req[(int'(ptr_r) + k) % NUM_SRC];
      pick_idx_s   = req[(int'(ptr_r) + k) % NUM_SRC] ?
                     SEL_W'((int'(ptr_r) + k) % NUM_SRC) : pick_idx_s;
    end
  end

  // One-hot AND-OR mux of the owner's pixel stream.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_color_s = 24'h000000;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_valid_s = sel_valid_s | (grant_r[i] & src_valid[i]);
      sel_color_s = sel_color_s | ({24{grant_r[i]}} & src_color[24*i +: 24]);
    end
  end

  // Zero-latency FIFO write path and back-pressure towards the owner.
  always_comb begin
    src_ready  = {NUM_SRC{1'b0}};
    fifo_wrreq = 1'b0;
    fifo_data  = 24'h000000;
    xfer_s     = 1'b0;
    case (state_r)
      STREAM: begin
        src_ready  = fifo_full ? {NUM_SRC{1'b0}} : grant_r;
        xfer_s     = sel_valid_s & ~fifo_full;
        fifo_wrreq = xfer_s;
        fifo_data  = xfer_s ? sel_color_s : 24'h000000;
      end
`ifdef LCD_SCHED_TIMEOUT_EN
      PAD: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = fifo_full ? 24'h000000 : PAD_COLOR;
      end
`endif
      default: begin
        src_ready  = {NUM_SRC{1'b0}};
        fifo_wrreq = 1'b0;
        fifo_data  = 24'h000000;
      end
    endcase
  end

  // Frame FSM: arbitration, pixel counting and drain hand-off.
  always_ff @(posedge clk_12) begin
    if (!rst) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_SRC{1'b0}};
      new_frame_r  <= {NUM_SRC{1'b0}};
      sel_r        <= {SEL_W{1'b0}};
      ptr_r        <= {SEL_W{1'b0}};
      pix_cnt_r    <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      aborted_r    <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
      stall_cnt_r  <= {STALL_W{1'b0}};
`endif
    end else begin
      new_frame_r  <= {NUM_SRC{1'b0}};
      frame_done_r <= 1'b0;
      aborted_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r <= NUM_SRC'(1) << pick_idx_s;
            sel_r   <= pick_idx_s;
            busy_r  <= 1'b1;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          new_frame_r <= grant_r;
          pix_cnt_r   <= {CNT_W{1'b0}};
`ifdef LCD_SCHED_TIMEOUT_EN
          stall_cnt_r <= {STALL_W{1'b0}};
`endif
          state_r     <= STREAM;
        end
        STREAM: begin
          // The final pixel leaves the counter parked so it can never wrap.
          if (xfer_s) begin
            if (pix_cnt_r == LAST_PIX) begin
              state_r <= DRAIN;
            end else begin
              pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
`ifdef LCD_SCHED_TIMEOUT_EN
            stall_cnt_r <= {STALL_W{1'b0}};
          end else if (!sel_valid_s && !fifo_full) begin
            if (stall_cnt_r == STALL_LAST) begin
              aborted_r <= 1'b1;
              state_r   <= PAD;
            end else begin
              stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end
`endif
          end else begin
            state_r <= STREAM;
          end
        end
`ifdef LCD_SCHED_TIMEOUT_EN
        PAD: begin
          if (!fifo_full) begin
            if (pix_cnt_r == LAST_PIX) begin
              state_r <= DRAIN;
            end else begin
              pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= PAD;
          end
        end
`endif
        DRAIN: begin
          if (fifo_empty) begin
            frame_done_r <= 1'b1;
            grant_r      <= {NUM_SRC{1'b0}};
            busy_r       <= 1'b0;
            ptr_r        <= (sel_r == LAST_SRC) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
            state_r      <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          grant_r <= {NUM_SRC{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign new_frame  = new_frame_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
`ifdef LCD_SCHED_TIMEOUT_EN
  assign aborted    = aborted_r;
`else
  assign aborted    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler with a small 8x4 frame and randomized sources.
module tb_lcd_frame_scheduler;
  localparam int NS    = 3;
  localparam int N_PIX = 32;

  logic          clk_12 = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [2:0]    new_frame;
  logic [2:0]    src_valid = 3'b000;
  logic [71:0]   src_color = 72'h0;
  logic [2:0]    src_ready;
  logic [23:0]   fifo_data;
  logic          fifo_wrreq;
  logic          fifo_full = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [2:0]    grant;
  logic          busy;
  logic          frame_done;
  logic          aborted;

  lcd_frame_scheduler #(.NUM_SRC(3), .H_ACTIVE(8), .V_ACTIVE(4)) dut (
    .clk_12(clk_12), .rst(rst), .req(req), .new_frame(new_frame),
    .src_valid(src_valid), .src_color(src_color), .src_ready(src_ready),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .grant(grant), .busy(busy),
    .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk_12 = ~clk_12;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round-robin order and pixel streams.
  int          model_ptr = 0;
  int          model_seq [NS];
  int          exp_grant_q [$];
  logic [23:0] exp_pix_q [$];

  // Source drivers.
  int   want [NS];
  int   idx  [NS];
  int   seq  [NS];
  bit   active [NS];
  int   cyc = 0;
  int   full_mode = 0;
  bit   empty_force = 1'b0;

  // Monitor state.
  bit         mon_en = 1'b0;
  logic [2:0] xfer_m = 3'b000, nf_m = 3'b000, gr_m = 3'b000;
  logic [2:0] prev_grant = 3'b000, exp_nf = 3'b000;
  bit         pend_done = 1'b0, in_drain = 1'b0, drain_arm = 1'b0;
  int         pix = 0;
  int         frames_done = 0;

  function automatic logic [23:0] color_of(input int s, input int sq, input int p);
    return {s[2:0], sq[4:0], p[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_epoch(input int w0, input int w1, input int w2);
    int pend [NS];
    int tot;
    pend[0] = w0; pend[1] = w1; pend[2] = w2;
    tot = w0 + w1 + w2;
    repeat (tot) begin
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (model_ptr + k) % NS;
        if (pend[s] > 0) begin
          exp_grant_q.push_back(s);
          for (int p = 0; p < N_PIX; p++) exp_pix_q.push_back(color_of(s, model_seq[s], p));
          model_seq[s]++;
          pend[s]--;
          model_ptr = (s + 1) % NS;
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_12); #1;
    cyc++;
    for (int s = 0; s < NS; s++) begin
      if (xfer_m[s] && active[s]) begin
        idx[s]++;
        if (idx[s] == N_PIX) begin active[s] = 1'b0; seq[s]++; end
      end
      if (nf_m[s]) begin
        active[s] = 1'b1; idx[s] = 0;
        if (want[s] > 0) want[s]--;
      end
      req[s] = (want[s] > 0);
      if (active[s]) begin
        src_valid[s] = ($urandom_range(0, 7) != 0);
        src_color[24*s +: 24] = color_of(s, seq[s], idx[s]);
      end else if (gr_m[s]) begin
        src_valid[s] = 1'b0;
        src_color[24*s +: 24] = 24'($urandom);
      end else begin
        src_valid[s] = 1'($urandom_range(0, 1));
        src_color[24*s +: 24] = 24'($urandom);
      end
    end
    case (full_mode)
      0:       fifo_full = 1'b0;
      1:       fifo_full = ((cyc / 3) % 2 == 1);
      default: fifo_full = ($urandom_range(0, 2) == 0);
    endcase
    fifo_empty = empty_force ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_epoch(input int w0, input int w1, input int w2, input int fmode, input bit hold);
    int target, budget, dc;
    want[0] = w0; want[1] = w1; want[2] = w2;
    model_epoch(w0, w1, w2);
    full_mode = fmode;
    empty_force = hold;
    target = frames_done + w0 + w1 + w2;
    budget = 0; dc = 0;
    while (frames_done < target && budget < 4000) begin
      step();
      budget++;
      if (hold && in_drain) begin
        dc++;
        if (dc == 50) begin
          check("drain_hold_busy", 32'(busy), 32'd1);
          check("drain_hold_no_done", 32'(frame_done), 32'd0);
          empty_force = 1'b0;
        end
      end
    end
    if (frames_done < target) check("epoch_timeout", frames_done, target);
    full_mode = 0;
    empty_force = 1'b0;
  endtask

  // Monitor: per-cycle protocol checks and scoreboard pops.
  always @(negedge clk_12) begin
    xfer_m = src_valid & src_ready;
    nf_m   = new_frame;
    gr_m   = grant;
    if (!mon_en) begin
      prev_grant = 3'b000; exp_nf = 3'b000; pend_done = 1'b0;
      in_drain = 1'b0; drain_arm = 1'b0; pix = 0;
    end else begin
      check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
      check("busy_vs_grant", 32'(busy), 32'(grant != 3'b000));
      check("ready_owner_only", 32'(src_ready & ~grant), 32'd0);
      if (fifo_full) check("quiet_when_full", 32'({fifo_wrreq, src_ready}), 32'd0);
      check("wrreq_eq_transfer", 32'(fifo_wrreq), 32'(|(src_valid & src_ready)));
      check("aborted_low", 32'(aborted), 32'd0);
      check("new_frame", 32'(new_frame), 32'(exp_nf));
      exp_nf = (grant != 3'b000 && prev_grant == 3'b000) ? grant : 3'b000;
      if (grant != 3'b000 && prev_grant == 3'b000) begin
        if (exp_grant_q.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
        else check("grant_order", 32'(grant), 32'd1 << exp_grant_q.pop_front());
      end
      if (prev_grant != 3'b000 && grant != 3'b000) check("grant_stable", 32'(grant), 32'(prev_grant));
      check("frame_done", 32'(frame_done), 32'(pend_done));
      if (pend_done) begin frames_done++; pend_done = 1'b0; end
      if (drain_arm) begin in_drain = 1'b1; drain_arm = 1'b0; end
      if (in_drain) begin
        check("drain_busy", 32'(busy), 32'd1);
        if (fifo_empty) begin pend_done = 1'b1; in_drain = 1'b0; end
      end
      if (fifo_wrreq) begin
        if (exp_pix_q.size() == 0) check("unexpected_write", 32'(fifo_data), 32'hFFFFFFFF);
        else check("fifo_data", 32'(fifo_data), 32'(exp_pix_q.pop_front()));
        pix++;
        if (pix == N_PIX) begin drain_arm = 1'b1; pix = 0; end
      end
      prev_grant = grant;
    end
  end

  initial begin
    int budget;
    for (int s = 0; s < NS; s++) begin
      want[s] = 0; idx[s] = 0; seq[s] = 0; active[s] = 1'b0; model_seq[s] = 0;
    end
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk_12);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    rst = 1'b1;
    step();
    mon_en = 1'b1;

    run_epoch(1, 0, 0, 0, 1'b0);
    run_epoch(1, 1, 1, 0, 1'b0);
    run_epoch(2, 1, 1, 1, 1'b0);
    run_epoch(0, 1, 0, 2, 1'b1);
    for (int e = 0; e < 6; e++) begin
      int a, b, c;
      a = $urandom_range(0, 2); b = $urandom_range(0, 2); c = $urandom_range(0, 2);
      if (a + b + c == 0) a = 1;
      run_epoch(a, b, c, $urandom_range(0, 2), 1'b0);
    end

    // Reset in the middle of a frame, then re-request from a clean pointer.
    want[0] = 0; want[1] = 1; want[2] = 1;
    model_epoch(0, 1, 1);
    full_mode = 2;
    budget = 0;
    while (!(pix >= 10 && grant != 3'b000) && budget < 2000) begin step(); budget++; end
    if (budget >= 2000) check("reset_setup_timeout", budget, 0);
    mon_en = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < NS; s++) begin want[s] = 0; active[s] = 1'b0; end
    step();
    @(negedge clk_12);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_new_frame", 32'(new_frame), 32'd0);
    check("midrst_src_ready", 32'(src_ready), 32'd0);
    check("midrst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("midrst_data", 32'(fifo_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    check("midrst_aborted", 32'(aborted), 32'd0);
    rst = 1'b1;
    exp_grant_q.delete();
    exp_pix_q.delete();
    model_ptr = 0;
    for (int s = 0; s < NS; s++) begin model_seq[s] = 0; seq[s] = 0; idx[s] = 0; end
    step();
    mon_en = 1'b1;
    run_epoch(1, 1, 1, 2, 1'b0);

    repeat (5) step();
    check("pix_queue_empty", exp_pix_q.size(), 0);
    check("grant_queue_empty", exp_grant_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
